uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo_if.sv | 15 +
 rtl/uart_bit_timer.sv | 34 +++
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path (and the matching receiver).
//   tx_state_t : transmitter frame states
//   PAR_*      : encodings of the PARITY parameter
//   baud_div   : clock cycles per UART bit for a given clock and baud rate
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Rounded to the nearest integer so the baud error stays within half a cycle.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Read port of a show-ahead FIFO.
//   fifo_data  : head word, valid whenever fifo_empty is low
//   fifo_empty : FIFO empty flag
//   fifo_rd    : pop strobe, one cycle per word
// master = the reader (drives fifo_rd), slave = the FIFO.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_rd;

  modport master (input fifo_data, input fifo_empty, output fifo_rd);
  modport slave  (output fifo_data, output fifo_empty, input fifo_rd);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer shared by the UART transmitter and receiver.
//   clk  : system clock
//   rst  : synchronous active-high reset (count -> 0)
//   load : restart the count at CLKS_PER_BIT-1
//   done : high on the last cycle of each bit period
// After a period ends the count reloads by itself, so consecutive bits need
// no further load pulses.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int            TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load || (cnt_reg == '0)) begin
      cnt_reg <= LAST;
    end else begin
      cnt_reg <= cnt_reg - TW'(1);
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a show-ahead FIFO.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   fifo  : FIFO read port (master side: fifo_data, fifo_empty in; fifo_rd out)
//   tx    : serial line, idle high, registered
//   busy  : high while a frame is in progress
// Frame: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS
// stop bits, each held CLKS_PER_BIT cycles. At least one idle cycle always
// separates frames because the pop can only happen in IDLE.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = baud_div(50_000_000, 115_200),
  parameter int DATA_W       = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_fifo_if.master        fifo,
  output logic                  tx,
  output logic                  busy
);

  if (CLKS_PER_BIT < 2 ||
      (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("uart_tx_fifo: illegal CLKS_PER_BIT, PARITY or STOP_BITS");
  end

  localparam int CW = $clog2(DATA_W) + 1;

  tx_state_t          state_reg, state_next;
  logic [DATA_W-1:0]  shreg_reg, shreg_next;
  logic [CW-1:0]      bit_cnt_reg, bit_cnt_next;
  logic               par_reg, par_next;
  logic               tx_reg, tx_next;
  logic               load;
  logic               bit_done;

  // Pop only from IDLE, and never while reset is asserted.
  assign fifo.fifo_rd = (state_reg == IDLE) && !fifo.fifo_empty && !rst;
  assign load         = fifo.fifo_rd;
  assign tx           = tx_reg;
  assign busy         = (state_reg != IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .done (bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      par_reg     <= 1'b0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      bit_cnt_reg <= bit_cnt_next;
      par_reg     <= par_next;
      tx_reg      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    par_next     = par_reg;
    tx_next      = tx_reg;

    unique case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (fifo.fifo_rd) begin
          state_next   = START;
          shreg_next   = fifo.fifo_data;
          bit_cnt_next = '0;
          // Parity is taken from the word as popped; the shift register
          // is destroyed while the data bits go out.
          par_next     = (^fifo.fifo_data) ^ (PARITY == PAR_ODD);
          tx_next      = 1'b0;
        end
      end

      START: begin
        if (bit_done) begin
          state_next   = DATA;
          tx_next      = shreg_reg[0];
          shreg_next   = shreg_reg >> 1;
          bit_cnt_next = '0;
        end
      end

      DATA: begin
        if (bit_done) begin
          if (bit_cnt_reg == CW'(DATA_W - 1)) begin
            bit_cnt_next = '0;
            if (PARITY != PAR_NONE) begin
              state_next = PAR;
              tx_next    = par_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            tx_next      = shreg_reg[0];
            shreg_next   = shreg_reg >> 1;
            bit_cnt_next = bit_cnt_reg + CW'(1);
          end
        end
      end

      PAR: begin
        if (bit_done) begin
          state_next   = STOP;
          tx_next      = 1'b1;
          bit_cnt_next = '0;
        end
      end

      STOP: begin
        tx_next = 1'b1;
        // bit_cnt_reg counts stop bits here.
        if (bit_done) begin
          if (bit_cnt_reg == CW'(STOP_BITS - 1)) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + CW'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT = 4.
//   DUT 0: no parity, 1 stop    DUT 1: even parity, 1 stop
//   DUT 2: odd parity, 1 stop   DUT 3: no parity, 2 stop
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_a [4];
  logic [3:0] empty_v = 4'hF;
  logic [3:0] rd_v, tx_v, busy_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_W(8)) bus0 ();
  uart_tx_fifo_if #(.DATA_W(8)) bus1 ();
  uart_tx_fifo_if #(.DATA_W(8)) bus2 ();
  uart_tx_fifo_if #(.DATA_W(8)) bus3 ();

  assign bus0.fifo_data = data_a[0];  assign bus0.fifo_empty = empty_v[0];
  assign bus1.fifo_data = data_a[1];  assign bus1.fifo_empty = empty_v[1];
  assign bus2.fifo_data = data_a[2];  assign bus2.fifo_empty = empty_v[2];
  assign bus3.fifo_data = data_a[3];  assign bus3.fifo_empty = empty_v[3];
  assign rd_v = {bus3.fifo_rd, bus2.fifo_rd, bus1.fifo_rd, bus0.fifo_rd};

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .fifo(bus0), .tx(tx_v[0]), .busy(busy_v[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo(bus1), .tx(tx_v[1]), .busy(busy_v[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .fifo(bus2), .tx(tx_v[2]), .busy(busy_v[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .fifo(bus3), .tx(tx_v[3]), .busy(busy_v[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pops one word on DUT d (caller is at a falling edge) and checks every
  // cycle of the frame against exp_bits (bit k = k-th bit on the line).
  task automatic send_frame(input int d, input logic [7:0] word,
                            input logic [11:0] exp_bits, input int nbits,
                            input string tag);
    logic [3:0] smp;
    int busy_n;
    int rd_n;
    data_a[d]  = word;
    empty_v[d] = 1'b0;
    #1;
    check({tag, " pop"}, 32'(rd_v[d]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    empty_v[d] = 1'b1;
    busy_n = 0;
    rd_n   = 0;
    smp    = '0;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < 4; k++) begin
        #1;
        smp[k] = tx_v[d];
        busy_n += int'(busy_v[d]);
        rd_n   += int'(rd_v[d]);
        @(negedge clk);
      end
      check($sformatf("%s bit%0d", tag, b), 32'(smp), 32'({4{exp_bits[b]}}));
    end
    #1;
    check({tag, " busy_len"}, 32'(busy_n), 32'(nbits * 4));
    check({tag, " extra_rd"}, 32'(rd_n), 32'd0);
    check({tag, " idle_busy"}, 32'(busy_v[d]), 32'd0);
    check({tag, " idle_tx"}, 32'(tx_v[d]), 32'd1);
    $display("frame %s word=%02h bits=%0d busy=%0d", tag, word, nbits, busy_n);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int         pops [4];
    int         pop_n;
    logic       tx_log [100];
    int         hi_n;
    int         tx0_n, rd_n, busy_n;

    for (int i = 0; i < 4; i++) data_a[i] = 8'h00;

    // Reset with words pending: no pop may be issued while rst is high.
    @(negedge clk);
    rst     = 1'b1;
    empty_v = 4'h0;
    @(negedge clk);
    #1;
    check("rst tx", 32'(tx_v), 32'hF);
    check("rst busy", 32'(busy_v), 32'h0);
    check("rst rd", 32'(rd_v), 32'h0);
    $display("reset tx=%h busy=%h rd=%h", tx_v, busy_v, rd_v);
    empty_v = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 8N1, 0x55: start, 1,0,1,0,1,0,1,0, stop
    send_frame(0, 8'h55, 12'(11'b1_01010101_0), 10, "t1_8n1_55");
    // 0xA5 has four ones: even parity 0, odd parity 1
    send_frame(1, 8'hA5, 12'(11'b1_0_10100101_0), 11, "t2_even_A5");
    send_frame(2, 8'hA5, 12'(11'b1_1_10100101_0), 11, "t2_odd_A5");
    // two stop bits: 8 high cycles after the last data bit
    send_frame(3, 8'hFF, 12'(11'b1_1_11111111_0), 11, "t4_2stop_FF");

    // Back-to-back 0x01 then 0x80.
    pop_n = 0;
    pops  = '{default: 0};
    data_a[0]  = 8'h01;
    empty_v[0] = 1'b0;
    for (int c = 0; c < 96; c++) begin
      #1;
      tx_log[c] = tx_v[0];
      if (rd_v[0]) begin
        if (pop_n < 4) pops[pop_n] = c;
        pop_n++;
      end
      @(negedge clk);
      if (c == 0) data_a[0] = 8'h80;
      if (pop_n == 2 && c == pops[1]) empty_v[0] = 1'b1;
    end
    empty_v[0] = 1'b1;
    hi_n = 0;
    for (int c = 37; c <= 41; c++) hi_n += int'(tx_log[c]);
    check("t3 pop_count", 32'(pop_n), 32'd2);
    check("t3 pop_gap", 32'(pops[1] - pops[0]), 32'd41);
    check("t3 last_data_bit", 32'(tx_log[36]), 32'd0);
    check("t3 gap_high", 32'(hi_n), 32'd5);
    check("t3 second_start", 32'(tx_log[42]), 32'd0);
    check("t3 second_bit0", 32'(tx_log[46]), 32'd0);
    check("t3 second_bit7", 32'(tx_log[74]), 32'd1);
    check("t3 second_stop", 32'(tx_log[78]), 32'd1);
    $display("b2b pops=%0d gap=%0d high_between=%0d", pop_n, pops[1] - pops[0], hi_n);
    @(negedge clk);

    // Reset during data bit 3 of 0xF7 (bit 3 = 0), with 0x3C queued behind it.
    data_a[0]  = 8'hF7;
    empty_v[0] = 1'b0;
    #1;
    check("t5 pop", 32'(rd_v[0]), 32'd1);
    @(negedge clk);
    data_a[0] = 8'h3C;
    for (int c = 1; c < 18; c++) @(negedge clk);
    #1;
    check("t5 pre_rst_tx", 32'(tx_v[0]), 32'd0);
    check("t5 pre_rst_busy", 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t5 rst_tx", 32'(tx_v[0]), 32'd1);
    check("t5 rst_busy", 32'(busy_v[0]), 32'd0);
    check("t5 rst_rd", 32'(rd_v[0]), 32'd0);
    $display("midframe reset tx=%b busy=%b rd=%b", tx_v[0], busy_v[0], rd_v[0]);
    rst = 1'b0;
    send_frame(0, 8'h3C, 12'(11'b1_00111100_0), 10, "t5_after_rst_3C");

    // Empty FIFO with toggling data: the line stays idle.
    empty_v[0] = 1'b1;
    tx0_n  = 0;
    rd_n   = 0;
    busy_n = 0;
    for (int c = 0; c < 1000; c++) begin
      data_a[0] = 8'(c);
      #1;
      tx0_n  += int'(!tx_v[0]);
      rd_n   += int'(rd_v[0]);
      busy_n += int'(busy_v[0]);
      @(negedge clk);
    end
    check("t6 tx_low", 32'(tx0_n), 32'd0);
    check("t6 rd", 32'(rd_n), 32'd0);
    check("t6 busy", 32'(busy_n), 32'd0);
    $display("idle 1000 cycles tx_low=%0d rd=%0d busy=%0d", tx0_n, rd_n, busy_n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
